// File: rtl/dtag_ctrl_pkg.sv
// Shared definitions for the D-cache tag controller: widths, FSM states,
// security domains and the victim-selection helper.
package dtag_ctrl_pkg;

  localparam int D_TAG_WIDTH   = 16;
  localparam int D_INDEX_WIDTH = 4;

  // Ways 0,1 belong to the L domain, ways 2,3 to the H domain.
  localparam logic DOM_L = 1'b0;
  localparam logic DOM_H = 1'b1;

  typedef enum logic [2:0] {
    DTC_IDLE,
    DTC_LOOKUP,
    DTC_REFILL_REQ,
    DTC_REFILL_WAIT,
    DTC_TAG_WRITE,
    DTC_RESP
  } dtc_state_e;

  // Victim inside the requester's way pair: first invalid way (lower first),
  // otherwise the way named by the replacement bit.
  function automatic logic [1:0] pick_victim(input logic dom, input logic [1:0] v,
                                             input logic rbit);
    if (!v[0])      return {dom, 1'b0};
    else if (!v[1]) return {dom, 1'b1};
    else            return {dom, rbit};
  endfunction

endpackage

// File: rtl/dtag_repl.sv
// Valid-bit array and per-set, per-domain replacement bits.
// Build option: DTAG_LRU_EN selects 1-bit LRU (updated on hits and fills);
// otherwise 1-bit round-robin that toggles on each allocation only.
module dtag_repl
  import dtag_ctrl_pkg::*;
#(
  parameter int AW = D_INDEX_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] set,
  input  logic          dom,
  input  logic          hit,
  input  logic [1:0]    hit_way,
  input  logic          alloc,
  input  logic [1:0]    alloc_way,
  output logic [3:0]    valid,
  output logic [1:0]    victim
);

  localparam int NUM = 1 << AW;

  logic [3:0] valid_q [NUM];
  logic [1:0] repl_q  [NUM];   // bit [d] = replacement pointer of domain d
  logic [1:0] dom_valid;

`ifndef DTAG_LRU_EN
  logic unused_hit;
  assign unused_hit = ^{hit, hit_way};
`endif

  // Valid bits and replacement state: set on allocation, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: this is a small flop array, not a RAM; every entry must be cleared
      // on reset because stale valid bits would produce false hits.
      for (int s = 0; s < NUM; s++) begin
        valid_q[s] <= '0;
        repl_q[s]  <= '0;
      end
    end else begin
      if (alloc) begin
        valid_q[set][alloc_way] <= 1'b1;
      end
`ifdef DTAG_LRU_EN
      if (alloc) begin
        repl_q[set][alloc_way[1]] <= ~alloc_way[0];
      end else if (hit) begin
        repl_q[set][hit_way[1]] <= ~hit_way[0];
      end
`else
      if (alloc) begin
        repl_q[set][alloc_way[1]] <= ~repl_q[set][alloc_way[1]];
      end
`endif
    end
  end

  assign valid     = valid_q[set];
  assign dom_valid = dom ? valid_q[set][3:2] : valid_q[set][1:0];
  assign victim    = pick_victim(dom, dom_valid, repl_q[set][dom]);

endmodule

// File: rtl/dtag_ctrl.sv
// Lookup/allocate controller for the 4-way D-cache tag RAM. Compares tags
// against combinational RAM read data, requests a refill on a miss and writes
// the new tag into a victim way of the requester's domain.
// Build option: DTAG_LRU_EN (LRU replacement instead of round-robin).
module dtag_ctrl
  import dtag_ctrl_pkg::*;
#(
  parameter int DW = D_TAG_WIDTH,
  parameter int AW = D_INDEX_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [DW-1:0] req_tag,
  input  logic [AW-1:0] req_index,
  input  logic          req_dom,
  output logic          resp_valid,
  output logic          resp_hit,
  output logic [1:0]    resp_way,
  output logic          refill_valid,
  input  logic          refill_ready,
  input  logic          refill_done,
  output logic [AW-1:0] tr_index,
  output logic [1:0]    tr_way,
  output logic [DW-1:0] tr_din,
  output logic          tr_we,
  output logic          tr_en,
  input  logic [DW-1:0] tr_dout0,
  input  logic [DW-1:0] tr_dout1,
  input  logic [DW-1:0] tr_dout2,
  input  logic [DW-1:0] tr_dout3
);

  dtc_state_e    state, state_nx;
  logic [DW-1:0] tag_q;
  logic [AW-1:0] idx_q;
  logic          dom_q;
  logic          hit_q;
  logic [1:0]    way_q;      // hit way, or victim way on a miss

  logic [DW-1:0] dout [4];
  logic [3:0]    valid_set;
  logic [1:0]    victim;
  logic [3:0]    hit_vec;
  logic          lookup_hit;
  logic [1:0]    lookup_way;

  assign dout[0] = tr_dout0;
  assign dout[1] = tr_dout1;
  assign dout[2] = tr_dout2;
  assign dout[3] = tr_dout3;

  dtag_repl #(.AW(AW)) u_repl (
    .clk       (clk),
    .rst       (rst),
    .set       (idx_q),
    .dom       (dom_q),
    .hit       ((state == DTC_LOOKUP) && lookup_hit),
    .hit_way   (lookup_way),
    .alloc     (state == DTC_TAG_WRITE),
    .alloc_way (way_q),
    .valid     (valid_set),
    .victim    (victim)
  );

  // Tag compare: L requesters see ways 0,1 only; H requesters see all four.
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < 4; w++) begin
      hit_vec[w] = valid_set[w] && (dout[w] == tag_q) && (dom_q == DOM_H || w < 2);
    end
  end

  assign lookup_hit = |hit_vec;
  assign lookup_way = hit_vec[0] ? 2'd0 : hit_vec[1] ? 2'd1 : hit_vec[2] ? 2'd2 : 2'd3;

  // State register and request/lookup holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DTC_IDLE;
      tag_q <= '0;
      idx_q <= '0;
      dom_q <= DOM_L;
      hit_q <= 1'b0;
      way_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      if (state == DTC_IDLE && req_valid) begin
        tag_q <= req_tag;
        idx_q <= req_index;
        dom_q <= req_dom;
      end
      if (state == DTC_LOOKUP) begin
        hit_q <= lookup_hit;
        way_q <= lookup_hit ? lookup_way : victim;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      DTC_IDLE:        if (req_valid)    state_nx = DTC_LOOKUP;
      DTC_LOOKUP:      state_nx = lookup_hit ? DTC_RESP : DTC_REFILL_REQ;
      DTC_REFILL_REQ:  if (refill_ready) state_nx = DTC_REFILL_WAIT;
      DTC_REFILL_WAIT: if (refill_done)  state_nx = DTC_TAG_WRITE;
      DTC_TAG_WRITE:   state_nx = DTC_RESP;
      DTC_RESP:        state_nx = DTC_IDLE;
      default:         state_nx = DTC_IDLE;
    endcase
  end

  // Outputs decoded from state; tag RAM strobes only in LOOKUP/TAG_WRITE.
  always_comb begin
    req_ready    = (state == DTC_IDLE);
    resp_valid   = (state == DTC_RESP);
    resp_hit     = (state == DTC_RESP) && hit_q;
    resp_way     = (state == DTC_RESP) ? way_q : 2'd0;
    refill_valid = (state == DTC_REFILL_REQ);
    tr_en        = (state == DTC_LOOKUP) || (state == DTC_TAG_WRITE);
    tr_we        = (state == DTC_TAG_WRITE);
    tr_index     = tr_en ? idx_q : '0;
    tr_way       = tr_we ? way_q : 2'd0;
    tr_din       = tr_we ? tag_q : '0;
  end

endmodule

// File: tb/tb_dtag_ctrl.sv
// Self-checking bench for dtag_ctrl: directed scenarios plus randomized
// requests compared against a set/way/valid/replacement reference model.
module tb_dtag_ctrl;
  import dtag_ctrl_pkg::*;

  localparam int DW  = D_TAG_WIDTH;
  localparam int AW  = D_INDEX_WIDTH;
  localparam int NUM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, req_valid, req_dom, refill_ready, refill_done;
  logic          req_ready, resp_valid, resp_hit, refill_valid, tr_we, tr_en;
  logic [DW-1:0] req_tag, tr_din, tr_dout0, tr_dout1, tr_dout2, tr_dout3;
  logic [AW-1:0] req_index, tr_index;
  logic [1:0]    resp_way, tr_way;

  int total = 0;
  int bad   = 0;

  // Tag RAM stand-in: combinational read, synchronous write.
  logic [DW-1:0] tram [NUM][4];
  // Reference model state.
  logic          m_valid [NUM][4];
  logic [DW-1:0] m_tag   [NUM][4];
  logic          m_repl  [NUM][2];

  always #5 clk = ~clk;

  dtag_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_index(req_index), .req_dom(req_dom),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_done(refill_done),
    .tr_index(tr_index), .tr_way(tr_way), .tr_din(tr_din), .tr_we(tr_we), .tr_en(tr_en),
    .tr_dout0(tr_dout0), .tr_dout1(tr_dout1), .tr_dout2(tr_dout2), .tr_dout3(tr_dout3)
  );

  assign tr_dout0 = tram[tr_index][0];
  assign tr_dout1 = tram[tr_index][1];
  assign tr_dout2 = tram[tr_index][2];
  assign tr_dout3 = tram[tr_index][3];

  always @(posedge clk) if (tr_we) tram[tr_index][tr_way] <= tr_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM; s++) begin
      for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
      m_repl[s][0] = 1'b0;
      m_repl[s][1] = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  32'(req_ready), 1);
    check({tag, "_resp"},   32'(resp_valid), 0);
    check({tag, "_refill"}, 32'(refill_valid), 0);
    check({tag, "_en"},     32'(tr_en), 0);
    check({tag, "_we"},     32'(tr_we), 0);
  endtask

  // One full request; abort=1 asserts rst while waiting for refill_done.
  task automatic do_req(input logic [DW-1:0] tag, input int idx, input logic dom,
                        input int rdy_delay, input int done_delay, input bit abort);
    bit       exp_hit = 1'b0;
    int       exp_way = 0;
    int       base;
    for (int w = 0; w < 4; w++) begin
      if (!exp_hit && (dom == DOM_H || w < 2) && m_valid[idx][w] && m_tag[idx][w] == tag) begin
        exp_hit = 1'b1;
        exp_way = w;
      end
    end
    if (!exp_hit) begin
      base = dom ? 2 : 0;
      if (!m_valid[idx][base])        exp_way = base;
      else if (!m_valid[idx][base+1]) exp_way = base + 1;
      else                            exp_way = base + int'(m_repl[idx][dom]);
    end

    req_valid = 1'b1; req_tag = tag; req_index = AW'(idx); req_dom = dom;
    check("accept_ready", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    check("lookup_en", 32'(tr_en), 1);
    check("lookup_we", 32'(tr_we), 0);
    check("lookup_idx", 32'(tr_index), 32'(idx));
    step();
    if (exp_hit) begin
      check("hit_resp_valid", 32'(resp_valid), 1);
      check("hit_resp_hit", 32'(resp_hit), 1);
      check("hit_resp_way", 32'(resp_way), 32'(exp_way));
      check("hit_no_refill", 32'(refill_valid), 0);
`ifdef DTAG_LRU_EN
      m_repl[idx][exp_way / 2] = ~exp_way[0];
`endif
    end else begin
      check("miss_no_resp", 32'(resp_valid), 0);
      for (int c = 0; c < rdy_delay; c++) begin
        check("refill_held", 32'(refill_valid), 1);
        check("refill_no_we", 32'(tr_we), 0);
        step();
      end
      refill_ready = 1'b1;
      check("refill_hs", 32'(refill_valid), 1);
      step();
      refill_ready = 1'b0;
      check("wait_refill_low", 32'(refill_valid), 0);
      if (abort) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("abort");
        model_reset();
        return;
      end
      for (int c = 0; c < done_delay; c++) begin
        check("wait_no_we", 32'(tr_we), 0);
        step();
      end
      refill_done = 1'b1;
      step();
      refill_done = 1'b0;
      check("tw_we", 32'(tr_we), 1);
      check("tw_en", 32'(tr_en), 1);
      check("tw_way", 32'(tr_way), 32'(exp_way));
      check("tw_din", 32'(tr_din), 32'(tag));
      check("tw_idx", 32'(tr_index), 32'(idx));
      step();
      check("miss_resp_valid", 32'(resp_valid), 1);
      check("miss_resp_hit", 32'(resp_hit), 0);
      check("miss_resp_way", 32'(resp_way), 32'(exp_way));
      m_valid[idx][exp_way] = 1'b1;
      m_tag[idx][exp_way]   = tag;
`ifdef DTAG_LRU_EN
      m_repl[idx][dom] = ~exp_way[0];
`else
      m_repl[idx][dom] = ~m_repl[idx][dom];
`endif
    end
    step();
    check("back_idle", 32'(req_ready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < NUM; s++)
      for (int w = 0; w < 4; w++) begin
        tram[s][w]  = '0;
        m_tag[s][w] = '0;
      end
    model_reset();
    rst = 1'b1; req_valid = 1'b0; req_tag = '0; req_index = '0; req_dom = 1'b0;
    refill_ready = 1'b0; refill_done = 1'b0;
    step(); step();
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_resp_hit", 32'(resp_hit), 0);
    check("reset_resp_way", 32'(resp_way), 0);
    check("reset_tr_index", 32'(tr_index), 0);
    check("reset_tr_way", 32'(tr_way), 0);
    check("reset_tr_din", 32'(tr_din), 0);

    // Directed scenarios.
    do_req(16'h12, 5, DOM_L, 0, 1, 0);    // miss -> way0
    do_req(16'h12, 5, DOM_L, 0, 0, 0);    // hit way0
    do_req(16'h34, 5, DOM_H, 1, 0, 0);    // H miss -> way2
    do_req(16'h34, 5, DOM_L, 0, 0, 0);    // way2 invisible to L -> way1
    do_req(16'h0a, 7, DOM_L, 0, 0, 0);    // way0
    do_req(16'h0b, 7, DOM_L, 0, 0, 0);    // way1
    do_req(16'h0c, 7, DOM_L, 10, 2, 0);   // replacement victim, slow ready
    refill_done = 1'b1;                   // stray refill_done in IDLE is ignored
    step();
    refill_done = 1'b0;
    check_idle_outputs("stray_done");
    do_req(16'h55, 3, DOM_L, 0, 1, 1);    // reset while in REFILL_WAIT
    do_req(16'h55, 3, DOM_L, 0, 0, 0);    // must miss again

    // Randomized traffic over a few sets and a small tag pool.
    for (int n = 0; n < 250; n++) begin
      do_req(DW'($urandom_range(7, 1)), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), ($urandom_range(40, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
